lsb_mem_ctrl: RTL and testbench

Data-side memory controller that serves load/store requests from the load-store buffer and the commit stage. It serialises each access onto the byte-wide, single-port RAM/IO bus. It returns a sign- or zero-extended load word with a one-cycle mem_valid pulse, or a one-cycle finish_store pulse when a store completes. One access is in flight at a time, and requests are held by the requester until acknowledged.

---
 rtl/lsb_mem_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_lsb_mem_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// lsb_mem_ctrl : serialises LSB loads and committed stores onto a byte-wide
//                single-port RAM/IO bus, one access in flight at a time.
// Revision     : 1.0
// ============================================================================
module lsb_mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        load_store_sgn,
  input  logic [5:0]  load_store_op,
  input  logic [31:0] load_store_addr,
  input  logic        store_req,
  input  logic [5:0]  store_op,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
  output logic        mem_valid,
  output logic [31:0] mem_res,
  output logic        finish_store,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  // Opcode values mirror the encoding in defines.v
  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LH  = 6'd11;
  localparam logic [5:0] OP_LBU = 6'd13;
  localparam logic [5:0] OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] res_q, res_d;
  logic        valid_q, valid_d;
  logic        fin_q, fin_d;
  logic [7:0]  dout_q, dout_d;
  logic [31:0] a_q, a_d;
  logic        wr_q, wr_d;

  logic [31:0] w_load_word;
  logic [7:0]  w_store_byte;
  logic        w_io_stall;
  logic        w_io_stall_new;

  function automatic logic [2:0] load_size(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU) return 3'd1;
    if (op == OP_LH || op == OP_LHU) return 3'd2;
    return 3'd4;
  endfunction

  function automatic logic [2:0] store_size(input logic [5:0] op);
    if (op == OP_SB) return 3'd1;
    if (op == OP_SH) return 3'd2;
    return 3'd4;
  endfunction

  assign w_io_stall     = (addr_q[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign w_io_stall_new = (store_addr[17:16] == IO_ADDR_HI) && io_buffer_full;

  // The last byte of a load is taken straight from mem_din on the finishing edge
  always_comb begin
    w_load_word = {mem_din, data_q[23:0]};
    case (size_q)
      3'd1:    w_load_word = sext_q ? {{24{mem_din[7]}}, mem_din}
                                    : {24'b0, mem_din};
      3'd2:    w_load_word = sext_q ? {{16{mem_din[7]}}, mem_din, data_q[7:0]}
                                    : {16'b0, mem_din, data_q[7:0]};
      default: ;
    endcase
  end

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    w_store_byte = data_q[7:0];
      2'd1:    w_store_byte = data_q[15:8];
      2'd2:    w_store_byte = data_q[23:16];
      default: w_store_byte = data_q[31:24];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    data_d  = data_q;
    res_d   = res_q;
    valid_d = 1'b0;
    fin_d   = 1'b0;
    dout_d  = dout_q;
    a_d     = a_q;
    wr_d    = wr_q;

    case (state_q)
      S_IDLE: begin
        if (store_req) begin
          state_d = S_STORE;
          addr_d  = store_addr;
          data_d  = store_data;
          size_d  = store_size(store_op);
          sext_d  = 1'b0;
          if (w_io_stall_new) begin
            wr_d  = 1'b0;
            cnt_d = 3'd0;
          end else begin
            wr_d   = 1'b1;
            a_d    = store_addr;
            dout_d = store_data[7:0];
            cnt_d  = 3'd1;
          end
        end else if (load_store_sgn && !rollback) begin
          state_d = S_LOAD;
          addr_d  = load_store_addr;
          data_d  = 32'b0;
          size_d  = load_size(load_store_op);
          sext_d  = (load_store_op == OP_LB) || (load_store_op == OP_LH);
          wr_d    = 1'b0;
          a_d     = load_store_addr;
          cnt_d   = 3'd1;
        end
      end

      S_LOAD: begin
        if (rollback) begin
          state_d = S_IDLE;
          wr_d    = 1'b0;
          cnt_d   = 3'd0;
        end else begin
          // cnt_q is the index of the current edge since acceptance
          if (cnt_q < size_q) a_d = addr_q + {29'b0, cnt_q};
          case (cnt_q)
            3'd2:    data_d[7:0]   = mem_din;
            3'd3:    data_d[15:8]  = mem_din;
            3'd4:    data_d[23:16] = mem_din;
            default: ;
          endcase
          if (cnt_q == size_q + 3'd1) begin
            res_d   = w_load_word;
            valid_d = 1'b1;
            cnt_d   = 3'd0;
            state_d = S_ACK;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      S_STORE: begin
        if (cnt_q == size_q) begin
          wr_d    = 1'b0;
          fin_d   = 1'b1;
          cnt_d   = 3'd0;
          state_d = S_ACK;
        end else if (w_io_stall) begin
          wr_d = 1'b0;
        end else begin
          wr_d   = 1'b1;
          a_d    = addr_q + {29'b0, cnt_q};
          dout_d = w_store_byte;
          cnt_d  = cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      size_q  <= 3'd0;
      sext_q  <= 1'b0;
      addr_q  <= 32'b0;
      data_q  <= 32'b0;
      res_q   <= 32'b0;
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
      dout_q  <= 8'b0;
      a_q     <= 32'b0;
      wr_q    <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      fin_q   <= fin_d;
      dout_q  <= dout_d;
      a_q     <= a_d;
      wr_q    <= wr_d;
    end
  end

  assign mem_valid    = valid_q;
  assign mem_res      = res_q;
  assign finish_store = fin_q;
  assign mem_dout     = dout_q;
  assign mem_a        = a_q;
  assign mem_wr       = wr_q;

endmodule
`default_nettype wire

// File: tb/tb_lsb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_lsb_mem_ctrl : directed and randomized checks of lsb_mem_ctrl against a
//                   byte-array reference model of memory contents.
// Revision        : 1.0
// ============================================================================
module tb_lsb_mem_ctrl;

  localparam logic [5:0] LB  = 6'd10;
  localparam logic [5:0] LH  = 6'd11;
  localparam logic [5:0] LW  = 6'd12;
  localparam logic [5:0] LBU = 6'd13;
  localparam logic [5:0] LHU = 6'd14;
  localparam logic [5:0] SB  = 6'd15;
  localparam logic [5:0] SH  = 6'd16;
  localparam logic [5:0] SW  = 6'd17;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic        load_store_sgn = 1'b0;
  logic [5:0]  load_store_op = 6'd0;
  logic [31:0] load_store_addr = 32'd0;
  logic        store_req = 1'b0;
  logic [5:0]  store_op = 6'd0;
  logic [31:0] store_addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        mem_valid;
  logic [31:0] mem_res;
  logic        finish_store;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram     [bit [31:0]];
  logic [7:0] ref_mem [bit [31:0]];

  always #5 clk = ~clk;

  lsb_mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .load_store_sgn (load_store_sgn),
    .load_store_op  (load_store_op),
    .load_store_addr(load_store_addr),
    .store_req      (store_req),
    .store_op       (store_op),
    .store_addr     (store_addr),
    .store_data     (store_data),
    .mem_valid      (mem_valid),
    .mem_res        (mem_res),
    .finish_store   (finish_store),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  // Bus-side memory: the byte addressed at edge E is on mem_din at edge E+2.
  // It pauses along with the rest of the system while rdy is low.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
      if (mem_wr) ram[mem_a] = mem_dout;
    end
  end

  function automatic int size_of(input logic [5:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic logic [7:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ram_get(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  // Little-endian assembly of n bytes, then two's-complement reinterpretation for signed ops
  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr);
    int     n = size_of(op);
    longint v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(ref_get(addr + 32'(i))) * (longint'(1) << (8 * i));
    if ((op == LB || op == LH) && v >= (longint'(1) << (8 * n - 1)))
      v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [5:0] op, input logic [31:0] addr,
                         input int freeze_after, input string tag);
    int          n      = size_of(op);
    logic [31:0] exp    = ref_load(op, addr);
    int          k      = 0;
    int          edges  = 0;
    bit          got    = 1'b0;
    bit          froze  = 1'b0;
    load_store_op   = op;
    load_store_addr = addr;
    load_store_sgn  = 1'b1;
    while (!got && edges < 40) begin
      if (!froze && freeze_after >= 0 && k == freeze_after) begin
        rdy = 1'b0;
        cyc();
        cyc();
        rdy   = 1'b1;
        edges += 2;
        froze = 1'b1;
        check({tag, "_frozen_valid"}, {31'b0, mem_valid}, 32'd0);
      end
      cyc();
      edges++;
      k++;
      if (k <= n) begin
        check({tag, "_addr"}, mem_a, addr + 32'(k - 1));
        check({tag, "_rd"}, {31'b0, mem_wr}, 32'd0);
      end
      got = mem_valid;
    end
    check({tag, "_valid_seen"}, {31'b0, got}, 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'(n + 2 + (froze ? 2 : 0)));
    check({tag, "_res"}, mem_res, exp);
    load_store_sgn = 1'b0;
    cyc();
    check({tag, "_pulse_end"}, {31'b0, mem_valid}, 32'd0);
  endtask

  task automatic do_store(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input int io_cycles, input string tag);
    int          n     = size_of(op);
    logic [7:0]  nb    = ref_get(addr + 32'(n));
    int          edges = 0;
    int          wrote = 0;
    bit          got   = 1'b0;
    for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = data[8*i +: 8];
    store_op       = op;
    store_addr     = addr;
    store_data     = data;
    store_req      = 1'b1;
    io_buffer_full = (io_cycles > 0);
    while (!got && edges < 40) begin
      cyc();
      edges++;
      if (edges <= io_cycles) check({tag, "_stall"}, {31'b0, mem_wr}, 32'd0);
      if (edges == io_cycles) io_buffer_full = 1'b0;
      if (mem_wr) begin
        check({tag, "_wa"}, mem_a, addr + 32'(wrote));
        check({tag, "_wd"}, {24'b0, mem_dout}, {24'b0, data[8*wrote +: 8]});
        wrote++;
      end
      got = finish_store;
    end
    check({tag, "_finish_seen"}, {31'b0, got}, 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'(n + 1 + io_cycles));
    check({tag, "_nbytes"}, 32'(wrote), 32'(n));
    check({tag, "_wr_low"}, {31'b0, mem_wr}, 32'd0);
    store_req = 1'b0;
    cyc();
    check({tag, "_pulse_end"}, {31'b0, finish_store}, 32'd0);
    for (int i = 0; i <= n; i++)
      check({tag, "_ram"}, {24'b0, ram_get(addr + 32'(i))},
            {24'b0, (i < n) ? ref_get(addr + 32'(i)) : nb});
  endtask

  initial begin
    logic [5:0] lops [5];
    logic [5:0] sops [3];
    int         edges;
    bit         got;
    lops = '{LB, LH, LW, LBU, LHU};
    sops = '{SB, SH, SW};

    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h200, 8'h80);
    preload(32'h210, 8'h00); preload(32'h211, 8'h80);
    preload(32'h302, 8'h5A); preload(32'h303, 8'hA5);
    preload(32'hFFFFFFFE, 8'hEF); preload(32'hFFFFFFFF, 8'hBE);
    preload(32'h0, 8'hAD);        preload(32'h1, 8'hDE);
    for (int i = 0; i < 260; i++) preload(32'h1000 + 32'(i), 8'($urandom));

    // Reset state
    rst = 1'b0;
    cyc();
    cyc();
    check("rst_valid",  {31'b0, mem_valid},    32'd0);
    check("rst_finish", {31'b0, finish_store}, 32'd0);
    check("rst_res",    mem_res,               32'd0);
    check("rst_dout",   {24'b0, mem_dout},     32'd0);
    check("rst_a",      mem_a,                 32'd0);
    check("rst_wr",     {31'b0, mem_wr},       32'd0);
    rst = 1'b1;
    cyc();

    // Loads with known constants
    do_load(LW, 32'h100, -1, "lw");
    check("lw_const", mem_res, 32'h12345678);
    do_load(LB, 32'h200, -1, "lb");
    check("lb_const", mem_res, 32'hFFFFFF80);
    do_load(LBU, 32'h200, -1, "lbu");
    check("lbu_const", mem_res, 32'h00000080);
    do_load(LH, 32'h210, -1, "lh");
    check("lh_const", mem_res, 32'hFFFF8000);
    do_load(LHU, 32'h210, -1, "lhu");
    check("lhu_const", mem_res, 32'h00008000);
    do_load(LW, 32'hFFFFFFFE, -1, "lw_wrap");
    check("lw_wrap_const", mem_res, 32'hDEADBEEF);

    // Stores, including an IO stall
    do_store(SH, 32'h300, 32'hAABBCCDD, 0, "sh");
    check("sh_byte0", {24'b0, ram_get(32'h300)}, 32'hDD);
    check("sh_byte2_untouched", {24'b0, ram_get(32'h302)}, 32'h5A);
    do_store(SB, 32'h30000, 32'h00000077, 3, "sb_io");

    // Store and load requested together: store first, load accepted 2 edges after the pulse edge
    for (int i = 0; i < 4; i++) ref_mem[32'h400 + 32'(i)] = 8'(32'hCAFEF00D >> (8 * i));
    store_op = SW; store_addr = 32'h400; store_data = 32'hCAFEF00D; store_req = 1'b1;
    load_store_op = LW; load_store_addr = 32'h100; load_store_sgn = 1'b1;
    edges = 0; got = 1'b0;
    while (!got && edges < 40) begin
      cyc();
      edges++;
      got = finish_store;
    end
    check("both_store_done", {31'b0, got}, 32'd1);
    check("both_store_latency", 32'(edges), 32'd5);
    store_req = 1'b0;
    cyc();
    check("both_no_early_accept", {31'b0, mem_valid}, 32'd0);
    cyc();
    check("both_load_accept_a", mem_a, 32'h100);
    edges = 0; got = 1'b0;
    while (!got && edges < 40) begin
      cyc();
      edges++;
      got = mem_valid;
    end
    check("both_load_latency", 32'(edges), 32'd5);
    check("both_load_res", mem_res, ref_load(LW, 32'h100));
    load_store_sgn = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++)
      check("both_store_ram", {24'b0, ram_get(32'h400 + 32'(i))}, {24'b0, ref_get(32'h400 + 32'(i))});

    // Rollback during a load
    load_store_op = LW; load_store_addr = 32'h100; load_store_sgn = 1'b1;
    cyc();
    cyc();
    check("rb_a_e1", mem_a, 32'h101);
    rollback = 1'b1;
    load_store_sgn = 1'b0;
    cyc();
    check("rb_wr", {31'b0, mem_wr}, 32'd0);
    rollback = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      got = got | mem_valid;
    end
    check("rb_no_valid", {31'b0, got}, 32'd0);
    check("rb_a_frozen", mem_a, 32'h101);
    // Rollback in idle blocks acceptance
    load_store_op = LB; load_store_addr = 32'h200; load_store_sgn = 1'b1; rollback = 1'b1;
    cyc();
    check("rb_idle_block", mem_a, 32'h101);
    rollback = 1'b0;
    do_load(LB, 32'h200, -1, "rb_after");

    // rdy low for two cycles mid-load
    do_load(LW, 32'h100, 3, "lw_frz");

    // Reset in the middle of a store
    store_op = SW; store_addr = 32'h500; store_data = 32'h11223344; store_req = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    check("rst_mid_wr",   {31'b0, mem_wr},   32'd0);
    check("rst_mid_a",    mem_a,             32'd0);
    check("rst_mid_dout", {24'b0, mem_dout}, 32'd0);
    check("rst_mid_res",  mem_res,           32'd0);
    rst = 1'b1;
    store_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      got = got | finish_store;
    end
    check("rst_mid_no_finish", {31'b0, got}, 32'd0);

    // Randomized traffic against the reference memory
    for (int it = 0; it < 40; it++) begin
      logic [31:0] a;
      a = 32'h1000 + 32'($urandom_range(0, 250));
      if ($urandom_range(0, 1) == 1)
        do_store(sops[$urandom_range(0, 2)], a, $urandom, 0, "rnd_st");
      else
        do_load(lops[$urandom_range(0, 4)], a, int'($urandom_range(0, 7)) - 2, "rnd_ld");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
